// File: rtl/voice_alloc_pkg.sv
// Shared types for the voice allocator: FSM states, slot record, age-tracker opcodes.
package voice_alloc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        UPDATE,
        ISSUE,
        WAIT_ACK,
        GAP
    } alloc_state_t;

    typedef struct packed {
        logic       on;
        logic [7:0] note;
        logic [7:0] vel;
        logic [2:0] age;
    } voice_slot_t;

    // What the age tracker does to its slot ages on the UPDATE edge
    typedef enum logic [1:0] {
        AGE_HOLD,
        AGE_ALLOC,
        AGE_TOUCH,
        AGE_CLEAR
    } age_op_t;

    localparam int AGE_MAX = 7;
    localparam int CNT_W   = 16;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-slot 3-bit age registers; reports the oldest active slot (highest age, ties to lowest index).
module voice_age_tracker
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 5,
    parameter int IDX_W      = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  age_op_t               op_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [NUM_VOICES-1:0] active_i,
    output logic [IDX_W-1:0]      oldest_o
);

    logic [NUM_VOICES-1:0][2:0] age_q;
    logic [2:0]                 best_age;
    logic                       found;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            age_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (op_i != AGE_HOLD && IDX_W'(i) == idx_i)
                    age_q[i] <= '0;
                else if (op_i == AGE_ALLOC && active_i[i] && age_q[i] != 3'(AGE_MAX))
                    age_q[i] <= age_q[i] + 3'd1;
            end
        end
    end

    always_comb begin
        oldest_o = '0;
        best_age = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_i[i] && (!found || age_q[i] > best_age)) begin
                found    = 1'b1;
                best_age = age_q[i];
                oldest_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// MIDI note events -> paced 5-slot voice bursts for the wave combiner.
// Optional oldest-voice stealing on a full table: define VOICE_STEAL_EN.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int                    NUM_VOICES  = 5,
    parameter logic [NUM_VOICES-1:0] ALLOC_MASK  = 5'b11110,
    parameter int                    ACK_TIMEOUT = 1024,
    parameter int                    MIN_GAP     = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       event_valid_in,
    output logic                       event_ready_out,
    input  logic                       event_is_on_in,
    input  logic [7:0]                 event_note_in,
    input  logic [7:0]                 event_vel_in,
    input  logic                       parsed_ready_in,
    output logic                       burst_change_out,
    output logic [NUM_VOICES-1:0]      on_array_out,
    output logic [16*NUM_VOICES-1:0]   burst_data_out,
    output logic [7:0]                 drop_count_out,
    output logic                       ack_timeout_out
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    alloc_state_t               state_q;
    logic                       ready_q, ev_on_q;
    logic [7:0]                 ev_note_q, ev_vel_q;
    logic                       match_hit_q, free_hit_q;
    logic [IDX_W-1:0]           match_idx_q, free_idx_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [NUM_VOICES-1:0]      on_q;
    logic [NUM_VOICES-1:0][7:0] note_q, vel_q;
    logic                       burst_change_q, ack_to_q;
    logic [NUM_VOICES-1:0]      on_array_q;
    logic [16*NUM_VOICES-1:0]   burst_data_q, burst_d;
    logic [7:0]                 drop_q;

    logic                       match_hit_d, free_hit_d, drop_d;
    logic [IDX_W-1:0]           match_idx_d, free_idx_d, tgt_idx_d, oldest_idx;
    age_op_t                    op_d, age_op;

    // Downward scan leaves the lowest matching / free index
    always_comb begin
        match_hit_d = 1'b0;
        match_idx_d = '0;
        free_hit_d  = 1'b0;
        free_idx_d  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (on_q[i] && note_q[i] == ev_note_q) begin
                match_hit_d = 1'b1;
                match_idx_d = IDX_W'(i);
            end
            if (ALLOC_MASK[i] && !on_q[i]) begin
                free_hit_d = 1'b1;
                free_idx_d = IDX_W'(i);
            end
        end
    end

    always_comb begin
        op_d      = AGE_HOLD;
        tgt_idx_d = match_idx_q;
        drop_d    = 1'b0;
        if (ev_on_q) begin
            if (match_hit_q) begin
                op_d = AGE_TOUCH;
            end else if (free_hit_q) begin
                op_d      = AGE_ALLOC;
                tgt_idx_d = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
                op_d      = AGE_ALLOC;
                tgt_idx_d = oldest_idx;
`else
                drop_d = 1'b1;
`endif
            end
        end else if (match_hit_q) begin
            op_d = AGE_CLEAR;
        end else begin
            drop_d = 1'b1;
        end
    end

`ifndef VOICE_STEAL_EN
    logic unused_oldest;
    assign unused_oldest = ^oldest_idx;
`endif

    assign age_op = (state_q == UPDATE && !drop_d) ? op_d : AGE_HOLD;

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_age (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .op_i     (age_op),
        .idx_i    (tgt_idx_d),
        .active_i (on_q),
        .oldest_o (oldest_idx)
    );

    always_comb begin
        burst_d = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            burst_d[16*i +: 16] = {note_q[i], vel_q[i]};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            ready_q        <= 1'b0;
            ev_on_q        <= 1'b0;
            ev_note_q      <= '0;
            ev_vel_q       <= '0;
            match_hit_q    <= 1'b0;
            match_idx_q    <= '0;
            free_hit_q     <= 1'b0;
            free_idx_q     <= '0;
            cnt_q          <= '0;
            on_q           <= '0;
            note_q         <= '0;
            vel_q          <= '0;
            burst_change_q <= 1'b0;
            on_array_q     <= '0;
            burst_data_q   <= '0;
            drop_q         <= '0;
            ack_to_q       <= 1'b0;
        end else begin
            burst_change_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (event_valid_in && ready_q) begin
                        ev_on_q   <= event_is_on_in && (event_vel_in != 8'd0);
                        ev_note_q <= event_note_in;
                        ev_vel_q  <= event_vel_in;
                        ready_q   <= 1'b0;
                        state_q   <= SEARCH;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SEARCH: begin
                    match_hit_q <= match_hit_d;
                    match_idx_q <= match_idx_d;
                    free_hit_q  <= free_hit_d;
                    free_idx_q  <= free_idx_d;
                    state_q     <= UPDATE;
                end
                UPDATE: begin
                    if (drop_d) begin
                        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                        state_q <= IDLE;
                    end else begin
                        on_q[tgt_idx_d]   <= ev_on_q;
                        note_q[tgt_idx_d] <= ev_on_q ? ev_note_q : 8'd0;
                        vel_q[tgt_idx_d]  <= ev_on_q ? ev_vel_q : 8'd0;
                        state_q           <= ISSUE;
                    end
                end
                ISSUE: begin
                    burst_change_q <= 1'b1;
                    on_array_q     <= on_q;
                    burst_data_q   <= burst_d;
                    cnt_q          <= '0;
                    state_q        <= (|on_q) ? WAIT_ACK : GAP;
                end
                WAIT_ACK: begin
                    if (parsed_ready_in) begin
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        ack_to_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(MIN_GAP - 1)) state_q <= IDLE;
                    else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign event_ready_out  = ready_q;
    assign burst_change_out = burst_change_q;
    assign on_array_out     = on_array_q;
    assign burst_data_out   = burst_data_q;
    assign drop_count_out   = drop_q;
    assign ack_timeout_out  = ack_to_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random events vs a slot-table model.
module tb_voice_allocator;

    localparam int NV = 5;
    localparam logic [NV-1:0] MASK = 5'b11110;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ev_valid = 1'b0, ev_on = 1'b0, parsed = 1'b0;
    logic [7:0]      ev_note = '0, ev_vel = '0;
    logic            ev_ready, strobe, ack_to;
    logic [NV-1:0]   on_arr;
    logic [16*NV-1:0] bdata;
    logic [7:0]      drops;

    int errors = 0;
    int checks = 0;

    bit         m_on[NV];
    logic [7:0] m_note[NV], m_vel[NV];
    int         m_age[NV];
    int         m_drops;

    voice_allocator dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .event_valid_in   (ev_valid),
        .event_ready_out  (ev_ready),
        .event_is_on_in   (ev_on),
        .event_note_in    (ev_note),
        .event_vel_in     (ev_vel),
        .parsed_ready_in  (parsed),
        .burst_change_out (strobe),
        .on_array_out     (on_arr),
        .burst_data_out   (bdata),
        .drop_count_out   (drops),
        .ack_timeout_out  (ack_to)
    );

    always #5 clk = ~clk;

    function automatic logic [NV-1:0] m_onarr();
        logic [NV-1:0] r = '0;
        for (int i = 0; i < NV; i++) r[i] = m_on[i];
        return r;
    endfunction

    function automatic logic [16*NV-1:0] m_data();
        logic [16*NV-1:0] r = '0;
        for (int i = 0; i < NV; i++) if (m_on[i]) r[16*i +: 16] = {m_note[i], m_vel[i]};
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_on[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
        m_drops = 0;
    endtask

    task automatic model_drop();
        if (m_drops < 255) m_drops++;
    endtask

    // Applies one event to the reference table; burst=1 when a burst must follow
    task automatic model_event(input bit is_on, input logic [7:0] n, input logic [7:0] v, output bit burst);
        int held = -1, slot = -1;
        burst = 0;
        for (int i = NV - 1; i >= 0; i--) if (m_on[i] && m_note[i] == n) held = i;
        if (is_on && v != 0) begin
            if (held >= 0) begin
                m_vel[held] = v; m_age[held] = 0; burst = 1;
            end else begin
                for (int i = NV - 1; i >= 0; i--) if (MASK[i] && !m_on[i]) slot = i;
`ifdef VOICE_STEAL_EN
                if (slot < 0) begin
                    int best = -1;
                    for (int i = 0; i < NV; i++) if (m_on[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
                    slot = best;
                end
`endif
                if (slot >= 0) begin
                    for (int i = 0; i < NV; i++) if (m_on[i] && i != slot && m_age[i] < 7) m_age[i]++;
                    m_on[slot] = 1; m_note[slot] = n; m_vel[slot] = v; m_age[slot] = 0; burst = 1;
                end else model_drop();
            end
        end else begin
            if (held >= 0) begin
                m_on[held] = 0; m_note[held] = 0; m_vel[held] = 0; m_age[held] = 0; burst = 1;
            end else model_drop();
        end
    endtask

    task automatic do_reset();
        rst_n = 0; ev_valid = 0; parsed = 0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
    endtask

    // Drives one event, reports whether/when a strobe came and what it carried
    task automatic do_event(input bit is_on, input logic [7:0] n, input logic [7:0] v, input bit ack,
                            output bit seen, output int lat, output logic [NV-1:0] oa, output logic [16*NV-1:0] bd);
        int t = 0;
        seen = 0; lat = 0; oa = '0; bd = '0;
        @(negedge clk);
        while (!ev_ready && t < 3000) begin @(negedge clk); t++; end
        checks++;
        if (!ev_ready) begin
            errors++;
            $display("FAIL ready_wait: event_ready_out still %b after %0d cycles, required 1", ev_ready, t);
            return;
        end
        ev_valid = 1; ev_on = is_on; ev_note = n; ev_vel = v;
        @(posedge clk);
        #1 ev_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (strobe) begin seen = 1; lat = k; oa = on_arr; bd = bdata; break; end
        end
        if (seen && ack && oa != '0) begin
            @(negedge clk) parsed = 1;
            @(negedge clk) parsed = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; ev_valid = 0; parsed = 0;
        #12;
        checks++;
        if ({ev_ready, strobe, on_arr, bdata, drops, ack_to} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b stb=%b on=%b data=%h drops=%0d to=%b, required all 0",
                     ev_ready, strobe, on_arr, bdata, drops, ack_to);
        end
        model_clear();
        @(negedge clk) rst_n = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (ev_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b, required 1", ev_ready);
        end
    endtask

    task automatic test_alloc();
        bit seen, eb; int lat; logic [NV-1:0] oa; logic [16*NV-1:0] bd;
        logic [7:0] notes[4] = '{8'd60, 8'd64, 8'd67, 8'd72};
        do_reset();
        model_event(1, 8'd60, 8'd100, eb);
        do_event(1, 8'd60, 8'd100, 1, seen, lat, oa, bd);
        checks++;
        if (!seen || lat != 3) begin errors++; $display("FAIL first_latency: seen=%b lat=%0d, required seen=1 lat=3", seen, lat); end
        checks++;
        if (oa !== 5'b00010 || bd[31:16] !== 16'h3C64 || bd !== m_data()) begin
            errors++; $display("FAIL first_burst: on=%b data=%h, required on=00010 slot1=3C64", oa, bd);
        end
        for (int i = 1; i < 4; i++) begin
            model_event(1, notes[i], 8'd100, eb);
            do_event(1, notes[i], 8'd100, 1, seen, lat, oa, bd);
        end
        checks++;
        if (oa !== 5'b11110 || bd !== m_data()) begin
            errors++; $display("FAIL fill_order: on=%b data=%h, required on=11110 data=%h", oa, bd, m_data());
        end
        model_event(0, 8'd64, 8'd0, eb);
        do_event(0, 8'd64, 8'd0, 1, seen, lat, oa, bd);
        checks++;
        if (!seen || oa !== 5'b11010 || bd[47:32] !== 16'h0000 || bd !== m_data()) begin
            errors++; $display("FAIL release_64: seen=%b on=%b data=%h, required on=11010 slot2=0", seen, oa, bd);
        end
    endtask

    task automatic test_retrigger();
        bit seen, eb; int lat; logic [NV-1:0] oa; logic [16*NV-1:0] bd;
        do_reset();
        model_event(1, 8'd60, 8'd100, eb);
        do_event(1, 8'd60, 8'd100, 1, seen, lat, oa, bd);
        model_event(1, 8'd60, 8'd40, eb);
        do_event(1, 8'd60, 8'd40, 1, seen, lat, oa, bd);
        checks++;
        if (!seen || oa !== 5'b00010 || bd[31:16] !== 16'h3C28 || bd !== m_data()) begin
            errors++; $display("FAIL retrigger: seen=%b on=%b data=%h, required on=00010 slot1=3C28", seen, oa, bd);
        end
    endtask

    task automatic test_full();
        bit seen, eb; int lat; logic [NV-1:0] oa; logic [16*NV-1:0] bd;
        logic [7:0] notes[4] = '{8'd60, 8'd64, 8'd67, 8'd72};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            model_event(1, notes[i], 8'd100, eb);
            do_event(1, notes[i], 8'd100, 1, seen, lat, oa, bd);
        end
        model_event(1, 8'd76, 8'd90, eb);
        do_event(1, 8'd76, 8'd90, 1, seen, lat, oa, bd);
`ifdef VOICE_STEAL_EN
        checks++;
        if (!seen || oa !== 5'b11110 || bd[31:16] !== 16'h4C5A || bd !== m_data()) begin
            errors++; $display("FAIL steal_oldest: seen=%b on=%b data=%h, required slot1=4C5A", seen, oa, bd);
        end
`else
        checks++;
        if (seen || drops !== 8'd1) begin
            errors++; $display("FAIL full_drop: strobe=%b drops=%0d, required strobe=0 drops=1", seen, drops);
        end
`endif
    endtask

    task automatic test_release();
        bit seen, eb; int lat; logic [NV-1:0] oa; logic [16*NV-1:0] bd;
        do_reset();
        model_event(0, 8'd61, 8'd0, eb);
        do_event(0, 8'd61, 8'd0, 1, seen, lat, oa, bd);
        checks++;
        if (seen || drops !== 8'd1) begin
            errors++; $display("FAIL unmatched_off: strobe=%b drops=%0d, required strobe=0 drops=1", seen, drops);
        end
        model_event(1, 8'd60, 8'd100, eb);
        do_event(1, 8'd60, 8'd100, 1, seen, lat, oa, bd);
        model_event(1, 8'd60, 8'd0, eb);
        do_event(1, 8'd60, 8'd0, 1, seen, lat, oa, bd);
        checks++;
        if (!seen || lat != 3 || oa !== '0 || bd !== '0) begin
            errors++; $display("FAIL empty_burst: seen=%b lat=%0d on=%b data=%h, required seen=1 lat=3 all 0", seen, lat, oa, bd);
        end
    endtask

    task automatic test_timeout_and_async_reset();
        bit seen, eb; int lat; logic [NV-1:0] oa; logic [16*NV-1:0] bd;
        do_reset();
        model_event(1, 8'd60, 8'd100, eb);
        do_event(1, 8'd60, 8'd100, 0, seen, lat, oa, bd);
        repeat (1023) @(posedge clk);
        #1;
        checks++;
        if (ack_to !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b after 1023 cycles, required 0", ack_to); end
        @(posedge clk); #1;
        checks++;
        if (ack_to !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b after 1024 cycles, required 1", ack_to); end
        model_event(1, 8'd60, 8'd90, eb);
        do_event(1, 8'd60, 8'd90, 0, seen, lat, oa, bd);
        checks++;
        if (!seen || oa !== m_onarr() || bd !== m_data()) begin
            errors++; $display("FAIL pre_reset_burst: on=%b data=%h, required on=%b data=%h", oa, bd, m_onarr(), m_data());
        end
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks++;
        if ({ev_ready, strobe, on_arr, bdata, drops, ack_to} !== '0) begin
            errors++; $display("FAIL async_reset: rdy=%b stb=%b on=%b data=%h drops=%0d to=%b, required all 0",
                               ev_ready, strobe, on_arr, bdata, drops, ack_to);
        end
        model_clear();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit seen, eb, is_on; int lat; logic [NV-1:0] oa; logic [16*NV-1:0] bd;
        logic [7:0] n, v;
        do_reset();
        for (int e = 0; e < 60; e++) begin
            is_on = ($urandom_range(0, 2) != 0);
            n = 8'(60 + $urandom_range(0, 5));
            v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            model_event(is_on, n, v, eb);
            do_event(is_on, n, v, 1, seen, lat, oa, bd);
            checks++;
            if (seen !== eb || (eb && lat != 3)) begin
                errors++; $display("FAIL rnd_strobe[%0d]: seen=%b lat=%0d, required seen=%b lat=3", e, seen, lat, eb);
            end
            if (eb) begin
                checks++;
                if (oa !== m_onarr() || bd !== m_data()) begin
                    errors++; $display("FAIL rnd_burst[%0d]: on=%b data=%h, required on=%b data=%h", e, oa, bd, m_onarr(), m_data());
                end
            end
            checks++;
            if (drops !== 8'(m_drops)) begin
                errors++; $display("FAIL rnd_drops[%0d]: got %0d, required %0d", e, drops, m_drops);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_retrigger();
        test_full();
        test_release();
        test_timeout_and_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
